// File: rtl/soc_miner_dma.sv
// Burst memory-to-memory copy engine on an AXI3 master; one burst in flight, read into buffer then written out.
// Address/data/response channels all honour valid/ready stalls; outputs are decoded from registered state only.
module soc_miner_dma #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 64,
   parameter int LEN_W     = 4,
   parameter int MAX_BURST = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_go,
   input  logic [ADDR_W-1:0] i_src_addr,
   input  logic [ADDR_W-1:0] i_dst_addr,
   input  logic [31:0]       i_length,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_error,
   output logic              o_m_awvalid,
   input  logic              i_m_awready,
   output logic [ADDR_W-1:0] o_m_awaddr,
   output logic [LEN_W-1:0]  o_m_awlen,
   output logic              o_m_wvalid,
   input  logic              i_m_wready,
   output logic [DATA_W-1:0] o_m_wdata,
   output logic              o_m_wlast,
   input  logic              i_m_bvalid,
   output logic              o_m_bready,
   input  logic [1:0]        i_m_bresp,
   output logic              o_m_arvalid,
   input  logic              i_m_arready,
   output logic [ADDR_W-1:0] o_m_araddr,
   output logic [LEN_W-1:0]  o_m_arlen,
   input  logic              i_m_rvalid,
   output logic              o_m_rready,
   input  logic [DATA_W-1:0] i_m_rdata,
   input  logic              i_m_rlast,
   input  logic [1:0]        i_m_rresp
);
   localparam int BYTES = DATA_W / 8;
   localparam int BSH   = $clog2(BYTES);
   localparam int NW    = $clog2(MAX_BURST + 1);
   localparam int IW    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [NW-1:0] ONE = NW'(1);
   localparam logic [NW-1:0] CAP = NW'(MAX_BURST);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_FINISH
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [31:0]       r_remain;
   logic [NW-1:0]     r_n;
   logic [NW-1:0]     r_cnt;
   logic              r_err;
   logic [DATA_W-1:0] r_buf [MAX_BURST];

   logic [12:0]       w_src_beats;
   logic [12:0]       w_dst_beats;
   logic [NW-1:0]     w_cap_rem;
   logic [NW-1:0]     w_cap_src;
   logic [NW-1:0]     w_cap_dst;
   logic [NW-1:0]     w_n;
   logic              w_rd_fire;
   logic              w_wr_fire;
   logic              w_wr_last;
   logic              w_b_fire;
   logic              w_b_err;
   logic              w_last_burst;

   function automatic logic [NW-1:0] f_cap(input logic [31:0] v);
      return (v > 32'(MAX_BURST)) ? CAP : v[NW-1:0];
   endfunction

   // Beats left before the next 4KB page on each side; a burst must never cross one.
   assign w_src_beats = (13'd4096 - {1'b0, r_src[11:0]}) >> BSH;
   assign w_dst_beats = (13'd4096 - {1'b0, r_dst[11:0]}) >> BSH;
   assign w_cap_rem   = f_cap(r_remain);
   assign w_cap_src   = f_cap(32'(w_src_beats));
   assign w_cap_dst   = f_cap(32'(w_dst_beats));

   always_comb begin
      w_n = w_cap_rem;
      if (w_cap_src < w_n) w_n = w_cap_src;
      if (w_cap_dst < w_n) w_n = w_cap_dst;
   end

   assign w_rd_fire    = (r_state == S_RD_DATA) && i_m_rvalid;
   assign w_wr_fire    = (r_state == S_WR_DATA) && i_m_wready;
   assign w_wr_last    = (r_cnt == r_n - ONE);
   assign w_b_fire     = (r_state == S_WR_RESP) && i_m_bvalid;
   assign w_b_err      = (i_m_bresp != 2'b00);
   assign w_last_burst = (r_remain == 32'(r_n)) || r_err || w_b_err;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (i_go) w_next = (i_length == 32'd0) ? S_FINISH : S_RD_ADDR;
         S_RD_ADDR: if (i_m_arready) w_next = S_RD_DATA;
         S_RD_DATA: if (w_rd_fire && i_m_rlast) w_next = S_WR_ADDR;
         S_WR_ADDR: if (i_m_awready) w_next = S_WR_DATA;
         S_WR_DATA: if (w_wr_fire && w_wr_last) w_next = S_WR_RESP;
         S_WR_RESP: if (w_b_fire) w_next = w_last_burst ? S_FINISH : S_RD_ADDR;
         S_FINISH:  w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_src    <= '0;
         r_dst    <= '0;
         r_remain <= '0;
         r_n      <= '0;
         r_cnt    <= '0;
         r_err    <= 1'b0;
      end else begin
         if (r_state == S_IDLE && i_go) begin
            r_src    <= i_src_addr;
            r_dst    <= i_dst_addr;
            r_remain <= i_length;
            r_err    <= 1'b0;
         end
         if (r_state == S_RD_ADDR && i_m_arready) begin
            r_n   <= w_n;
            r_cnt <= '0;
         end
         if (w_rd_fire) begin
            if (r_cnt != '1) r_cnt <= r_cnt + ONE;
            if (i_m_rresp != 2'b00 || (i_m_rlast && (r_cnt + ONE) != r_n)) r_err <= 1'b1;
         end
         if (r_state == S_WR_ADDR && i_m_awready) r_cnt <= '0;
         if (w_wr_fire) r_cnt <= r_cnt + ONE;
         if (w_b_fire) begin
            r_src    <= r_src + (ADDR_W'(r_n) << BSH);
            r_dst    <= r_dst + (ADDR_W'(r_n) << BSH);
            r_remain <= r_remain - 32'(r_n);
            if (w_b_err) r_err <= 1'b1;
         end
      end
   end

   // Beats past the buffer depth (malformed slave) are dropped; the rlast count check flags them.
   always_ff @(posedge i_clk) begin
      if (w_rd_fire && r_cnt < CAP) r_buf[r_cnt[IW-1:0]] <= i_m_rdata;
   end

   always_comb begin
      o_m_arvalid = 1'b0;
      o_m_araddr  = '0;
      o_m_arlen   = '0;
      o_m_rready  = 1'b0;
      o_m_awvalid = 1'b0;
      o_m_awaddr  = '0;
      o_m_awlen   = '0;
      o_m_wvalid  = 1'b0;
      o_m_wdata   = '0;
      o_m_wlast   = 1'b0;
      o_m_bready  = 1'b0;
      o_done      = 1'b0;
      case (r_state)
         S_RD_ADDR: begin
            o_m_arvalid = 1'b1;
            o_m_araddr  = r_src;
            o_m_arlen   = LEN_W'(w_n - ONE);
         end
         S_RD_DATA: o_m_rready = 1'b1;
         S_WR_ADDR: begin
            o_m_awvalid = 1'b1;
            o_m_awaddr  = r_dst;
            o_m_awlen   = LEN_W'(r_n - ONE);
         end
         S_WR_DATA: begin
            o_m_wvalid = 1'b1;
            o_m_wdata  = r_buf[r_cnt[IW-1:0]];
            o_m_wlast  = w_wr_last;
         end
         S_WR_RESP: o_m_bready = 1'b1;
         S_FINISH:  o_done     = 1'b1;
         default:   o_done     = 1'b0;
      endcase
   end

   assign o_busy  = (r_state != S_IDLE) && (r_state != S_FINISH);
   assign o_error = r_err;

endmodule

// File: tb/tb_soc_miner_dma.sv
// Bench for soc_miner_dma: AXI slave model with optional random stalls, burst-plan model and directed copies.
module tb_soc_miner_dma;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_go;
   logic [31:0] i_src, i_dst, i_length;
   logic        o_busy, o_done, o_error;
   logic        o_m_awvalid, awready, o_m_wvalid, wready, o_m_wlast, bvalid, o_m_bready;
   logic [31:0] o_m_awaddr, o_m_araddr;
   logic [3:0]  o_m_awlen, o_m_arlen;
   logic [63:0] o_m_wdata, rdata;
   logic [1:0]  bresp, rresp;
   logic        o_m_arvalid, arready, rvalid, o_m_rready, rlast;

   always #5 clk = ~clk;

   soc_miner_dma dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_go(i_go), .i_src_addr(i_src), .i_dst_addr(i_dst),
      .i_length(i_length), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
      .o_m_awvalid(o_m_awvalid), .i_m_awready(awready), .o_m_awaddr(o_m_awaddr), .o_m_awlen(o_m_awlen),
      .o_m_wvalid(o_m_wvalid), .i_m_wready(wready), .o_m_wdata(o_m_wdata), .o_m_wlast(o_m_wlast),
      .i_m_bvalid(bvalid), .o_m_bready(o_m_bready), .i_m_bresp(bresp),
      .o_m_arvalid(o_m_arvalid), .i_m_arready(arready), .o_m_araddr(o_m_araddr), .o_m_arlen(o_m_arlen),
      .i_m_rvalid(rvalid), .o_m_rready(o_m_rready), .i_m_rdata(rdata), .i_m_rlast(rlast), .i_m_rresp(rresp)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] pat(input logic [31:0] a);
      return {a ^ 32'h5A5A_F00D, ~a};
   endfunction

   // slave configuration and state
   bit          stall = 0;
   bit          hold  = 1;
   int          slverr_idx = -1;
   logic [31:0] exp_ar_addr[$], exp_aw_addr[$];
   int          exp_ar_len[$], exp_aw_len[$];
   logic [31:0] ar_log[$], aw_log[$];
   int          arlen_log[$], awlen_log[$];
   logic [63:0] wmem [logic [31:0]];
   int          b_cnt = 0;
   bit          rd_act = 0, wr_act = 0;
   logic [31:0] rd_addr, wr_addr;
   int          rd_len, wr_len, rd_beat, wr_beat, b_pend;
   bit          p_ar = 0, p_aw = 0, p_w = 0;
   logic [31:0] p_araddr, p_awaddr;
   logic [3:0]  p_arlen, p_awlen;
   logic [63:0] p_wdata;

   function automatic bit rnd();
      return stall ? bit'($urandom_range(0, 1)) : 1'b1;
   endfunction

   // Burst plan straight from the copy rules: each burst is the smallest of remaining,
   // 16 beats, and the room left in the 4KB page on either side.
   task automatic build_model(input logic [31:0] s, input logic [31:0] d, input int len);
      int rem, n, sb, db;
      logic [31:0] ss, dd;
      exp_ar_addr.delete(); exp_ar_len.delete(); exp_aw_addr.delete(); exp_aw_len.delete();
      rem = len; ss = s; dd = d;
      while (rem > 0) begin
         sb = (4096 - int'(ss & 32'hFFF)) / 8;
         db = (4096 - int'(dd & 32'hFFF)) / 8;
         n = rem;
         if (n > 16) n = 16;
         if (n > sb) n = sb;
         if (n > db) n = db;
         exp_ar_addr.push_back(ss); exp_ar_len.push_back(n - 1);
         exp_aw_addr.push_back(dd); exp_aw_len.push_back(n - 1);
         ss += 32'(n * 8); dd += 32'(n * 8); rem -= n;
      end
   endtask

   // compare process: slave model plus per-cycle protocol and burst checks
   initial begin
      forever begin
         @(negedge clk);
         if (hold) begin
            arready = 0; awready = 0; wready = 0; rvalid = 0; rlast = 0; rdata = '0;
            bvalid = 0; bresp = 0; rresp = 0;
            rd_act = 0; wr_act = 0; b_pend = 0; p_ar = 0; p_aw = 0; p_w = 0;
         end else begin
            if (p_ar) check("ar_stable", {o_m_arvalid, o_m_arlen, o_m_araddr}, {1'b1, p_arlen, p_araddr});
            if (p_aw) check("aw_stable", {o_m_awvalid, o_m_awlen, o_m_awaddr}, {1'b1, p_awlen, p_awaddr});
            if (p_w) begin
               check("w_stable_valid", o_m_wvalid, 1);
               check("w_stable_data", o_m_wdata, p_wdata);
            end
            arready = rnd(); awready = rnd(); wready = rnd(); rresp = 2'b00;
            if (rd_act) begin
               rvalid = rnd();
               rdata  = pat(rd_addr + 32'(rd_beat * 8));
               rlast  = (rd_beat == rd_len);
            end else begin
               rvalid = 0; rlast = 0; rdata = '0;
            end
            bvalid = (b_pend > 0) && rnd();
            bresp  = (b_cnt == slverr_idx) ? 2'b10 : 2'b00;

            if (rvalid && o_m_rready) begin
               rd_beat++;
               if (rlast) rd_act = 0;
            end
            if (o_m_arvalid && arready) begin
               if (exp_ar_addr.size() == 0) check("ar_extra", 1, 0);
               else begin
                  check("araddr", o_m_araddr, exp_ar_addr.pop_front());
                  check("arlen", o_m_arlen, exp_ar_len.pop_front());
               end
               ar_log.push_back(o_m_araddr); arlen_log.push_back(int'(o_m_arlen));
               rd_act = 1; rd_addr = o_m_araddr; rd_len = int'(o_m_arlen); rd_beat = 0;
            end
            if (o_m_wvalid && wready) begin
               if (!wr_act) check("w_extra", 1, 0);
               else begin
                  wmem[wr_addr + 32'(wr_beat * 8)] = o_m_wdata;
                  check("wlast", o_m_wlast, wr_beat == wr_len);
                  wr_beat++;
                  if (wr_beat > wr_len) begin
                     wr_act = 0;
                     b_pend++;
                  end
               end
            end
            if (o_m_awvalid && awready) begin
               if (exp_aw_addr.size() == 0) check("aw_extra", 1, 0);
               else begin
                  check("awaddr", o_m_awaddr, exp_aw_addr.pop_front());
                  check("awlen", o_m_awlen, exp_aw_len.pop_front());
               end
               aw_log.push_back(o_m_awaddr); awlen_log.push_back(int'(o_m_awlen));
               wr_act = 1; wr_addr = o_m_awaddr; wr_len = int'(o_m_awlen); wr_beat = 0;
            end
            if (bvalid && o_m_bready) begin
               b_pend--;
               b_cnt++;
            end
            p_ar = o_m_arvalid && !arready; p_araddr = o_m_araddr; p_arlen = o_m_arlen;
            p_aw = o_m_awvalid && !awready; p_awaddr = o_m_awaddr; p_awlen = o_m_awlen;
            p_w  = o_m_wvalid && !wready;   p_wdata  = o_m_wdata;
         end
      end
   end

   task automatic clear_logs();
      wmem.delete(); ar_log.delete(); aw_log.delete(); arlen_log.delete(); awlen_log.delete();
      b_cnt = 0;
   endtask

   task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int len,
                           input int exp_bursts, input int n_words, input bit exp_err,
                           input bit go_while_busy);
      int cyc, busy_gap;
      logic [63:0] got;
      build_model(s, d, len);
      clear_logs();
      @(negedge clk);
      i_src = s; i_dst = d; i_length = 32'(len); i_go = 1;
      @(negedge clk);
      i_go = 0; i_src = 32'hDEAD_0000; i_dst = 32'hBEEF_0000; i_length = 32'd3;
      check("err_after_go", o_error, 0);
      cyc = 0; busy_gap = 0;
      while (!o_done && cyc < 5000) begin
         if (!o_busy) busy_gap++;
         if (go_while_busy && cyc == 20) begin
            i_go = 1; i_src = 32'h7000; i_dst = 32'h7800; i_length = 32'd5;
         end else i_go = 0;
         @(negedge clk);
         cyc++;
      end
      i_go = 0;
      check("done_seen", o_done, 1);
      check("busy_at_done", o_busy, 0);
      check("busy_gap", busy_gap, 0);
      check("error_flag", o_error, exp_err);
      check("ar_count", ar_log.size(), exp_bursts);
      check("aw_count", aw_log.size(), exp_bursts);
      check("b_count", b_cnt, exp_bursts);
      for (int i = 0; i < n_words; i++) begin
         got = wmem.exists(d + 32'(i * 8)) ? wmem[d + 32'(i * 8)] : 64'hBAD0_BAD0_BAD0_BAD0;
         check("dst_data", got, pat(s + 32'(i * 8)));
      end
      @(negedge clk);
      check("done_one_cycle", o_done, 0);
   endtask

   initial begin
      int cyc;
      rst_n = 0; i_go = 0; i_src = '0; i_dst = '0; i_length = '0;
      arready = 0; awready = 0; wready = 0; rvalid = 0; rlast = 0; rdata = '0;
      bvalid = 0; bresp = 0; rresp = 0;
      #1;
      check("reset_ctrl", {o_busy, o_done, o_error, o_m_arvalid, o_m_awvalid, o_m_wvalid,
                           o_m_wlast, o_m_rready, o_m_bready, o_m_arlen, o_m_awlen}, 0);
      check("reset_addr", {o_m_araddr, o_m_awaddr}, 0);
      repeat (3) @(negedge clk);
      rst_n = 1; hold = 0;

      // single 8-beat burst
      run_copy(32'h1000, 32'h2000, 8, 1, 8, 0, 0);
      check("t1_araddr", ar_log[0], 32'h1000);
      check("t1_arlen", arlen_log[0], 7);
      check("t1_awaddr", aw_log[0], 32'h2000);
      check("t1_awlen", awlen_log[0], 7);

      // 40 beats -> 16/16/8, with a stray Go mid-transfer
      run_copy(32'h1000, 32'h2000, 40, 3, 40, 0, 1);
      check("t2_ar1", ar_log[1], 32'h1080);
      check("t2_ar2", ar_log[2], 32'h1100);
      check("t2_len0", arlen_log[0], 15);
      check("t2_len2", arlen_log[2], 7);
      check("t2_aw2", aw_log[2], 32'h2100);

      // 4KB split on the source
      run_copy(32'h0FE0, 32'h3000, 8, 2, 8, 0, 0);
      check("t3_ar0", ar_log[0], 32'h0FE0);
      check("t3_len0", arlen_log[0], 3);
      check("t3_ar1", ar_log[1], 32'h1000);
      check("t3_aw1", aw_log[1], 32'h3020);

      // random stalls on every channel: 16 beats to the page edge, then 14
      stall = 1;
      run_copy(32'h4F80, 32'h6010, 30, 2, 30, 0, 0);
      check("t4_len1", arlen_log[1], 13);
      stall = 0;

      // SLVERR on the first write response stops after that burst
      slverr_idx = 0;
      run_copy(32'h1000, 32'h2000, 40, 1, 16, 1, 0);
      slverr_idx = -1;
      run_copy(32'h1000, 32'h2000, 8, 1, 8, 0, 0);

      // zero-length request
      clear_logs();
      @(negedge clk);
      i_length = 0; i_src = 32'h1000; i_dst = 32'h2000; i_go = 1;
      @(negedge clk);
      i_go = 0;
      check("len0_done", o_done, 1);
      check("len0_busy", o_busy, 0);
      @(negedge clk);
      check("len0_done_off", o_done, 0);
      repeat (4) @(negedge clk);
      check("len0_no_ar", ar_log.size(), 0);
      check("len0_no_aw", aw_log.size(), 0);

      // reset in the middle of a read burst
      build_model(32'h1000, 32'h2000, 40);
      clear_logs();
      @(negedge clk);
      i_src = 32'h1000; i_dst = 32'h2000; i_length = 40; i_go = 1;
      @(negedge clk);
      i_go = 0;
      cyc = 0;
      while (!(o_m_rready && rd_act && rd_beat >= 3) && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("rst_reached_rdata", o_m_rready, 1);
      #2;
      hold = 1; rst_n = 0;
      #1;
      check("rst_mid_ctrl", {o_busy, o_done, o_error, o_m_arvalid, o_m_awvalid, o_m_wvalid,
                             o_m_wlast, o_m_rready, o_m_bready, o_m_arlen, o_m_awlen}, 0);
      check("rst_mid_addr", {o_m_araddr, o_m_awaddr}, 0);
      check("rst_mid_wdata", o_m_wdata, 0);
      repeat (3) @(negedge clk);
      rst_n = 1; hold = 0;
      repeat (10) @(negedge clk);
      check("rst_no_more_ar", ar_log.size(), 1);
      check("rst_no_aw", aw_log.size(), 0);
      check("rst_idle", o_busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/soc_miner_dma.md
Name: soc_miner_dma

Overview:
- Parametrised memory-to-memory copy engine that drives the miner's 64-bit AXI3 memory master port, which was previously tied off.
- Software programs source address, destination address and length through the register block, then pulses go.
- The engine copies the data in bursts through an internal buffer: read a burst into the buffer, then write it back out.
- It reports busy, a done pulse and a sticky error flag back to the register block.

Parameters:
ADDR_W, 32, memory address width
DATA_W, 64, memory data width; power of 2, ≥32
LEN_W, 4, AXI ax*len field width
MAX_BURST, 16, buffer depth and maximum beats per burst; must be ≤2^LEN_W

Ports:
Clk  in  1  clock
Rst_n  in  1  reset; asynchronous, active-low
Go  in  1  start pulse, one cycle
Src_addr  in  ADDR_W  source byte address; DATA_W/8 aligned
Dst_addr  in  ADDR_W  destination byte address; DATA_W/8 aligned
Length  in  32  transfer length in DATA_W words
Busy  out  1  copy in progress
Done  out  1  one-cycle completion pulse
Error  out  1  sticky: a non-OKAY response was seen
m_awvalid  out  1  write address valid
m_awready  in  1  write address ready
m_awaddr  out  ADDR_W  write burst address
m_awlen  out  LEN_W  beats-1
m_wvalid  out  1  write data valid
m_wready  in  1  write data ready
m_wdata  out  DATA_W  write data
m_wlast  out  1  final beat of write burst
m_bvalid  in  1  write response valid
m_bready  out  1  write response ready
m_bresp  in  2  write response
m_arvalid  out  1  read address valid
m_arready  in  1  read address ready
m_araddr  out  ADDR_W  read burst address
m_arlen  out  LEN_W  beats-1
m_rvalid  in  1  read data valid
m_rready  out  1  read data ready
m_rdata  in  DATA_W  read data
m_rlast  in  1  final beat of read burst
m_rresp  in  2  read response

Behaviour:
- Wrapper ties off signals not driven here: size = log2(DATA_W/8), burst = INCR, strb = all ones, id = 0, lock/cache/prot/qos = 0.
- Reset: every output is 0 and the FSM is in IDLE. Reset asserted mid-transfer drops all valids immediately; no further handshakes are issued.
- FSM states: IDLE → RD_ADDR → RD_DATA → WR_ADDR → WR_DATA → WR_RESP → (RD_ADDR | FINISH) → IDLE.
- IDLE:
  - Go with Length=0: Done pulses the next cycle; Busy stays 0; no bus traffic.
  - Go with Length>0: latch Src/Dst/Length; Busy=1 from the next cycle until the cycle Done is asserted.
  - Go while Busy is ignored.
  - Error clears when a Go is accepted.
- Burst size, in beats: min(remaining, MAX_BURST, beats to the next 4KB boundary of src, beats to the next 4KB boundary of dst). Computed in RD_ADDR; ≥1 by construction.
- Address channels: valid asserts on state entry. addr/len hold stable until ready. Advance on valid&&ready.
- RD_DATA:
  - rready=1 throughout; the buffer always has room.
  - Beats are stored at index 0..n-1.
  - Leave on rvalid&&rready&&rlast. An rlast arriving on a beat count ≠ n sets Error.
- WR_DATA:
  - wvalid=1 with wdata=buf[idx].
  - wlast=1 when idx==n-1.
  - idx advances on wvalid&&wready.
- WR_RESP:
  - bready=1.
  - On bvalid: src += n*DATA_W/8, dst likewise, remaining -= n.
  - If remaining==0 or Error is set → FINISH; otherwise → RD_ADDR.
- Errors: rresp≠0 or bresp≠0 sets Error. The current burst's handshakes complete fully (the write phase still runs, with the data as read), then the engine goes to FINISH. No new burst starts.
- FINISH: Done=1 for one cycle, Busy=0 in the same cycle, then IDLE.
- Only one burst is outstanding at a time. Read and write phases never overlap.

Test Plan:
- Src=0x1000, Dst=0x2000, Length=8, always-ready memory model → one AR (len=7) and one AW (len=7); destination matches source; Done after the B response; Error=0.
- Length=40, MAX_BURST=16 → bursts of 16, 16, 8 beats; addresses advance by 0x80 each; exactly 3 B responses, then Done.
- Src=0x0FE0, Length=8, DATA_W=64 → first burst of 4 beats (stops at 4KB), second of 4 starting at 0x1000; data is correct.
- Random stalls on arready/rvalid/awready/wready/bvalid → addr/len/wdata stay stable while stalled; data is correct; wlast only on the final beat of each burst.
- bresp=SLVERR on the first of 3 bursts → no second AR; Done pulses; Error=1; a new Go clears Error.
- Length=0 → Done the next cycle with no bus activity. Go while Busy → ignored. Rst_n low mid-RD_DATA → all outputs 0 at once.
